// File: rtl/mod_divide.sv
// ============================================================================
// Module   : mod_divide
// Brief    : Sequential IEEE-754 binary16 divider (restoring, truncating).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_divide (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic        in_En,
    output logic [15:0] out_Out,
    output logic        out_Ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] C_QNAN      = 16'h7E00;
    localparam logic [3:0]  C_LAST_ITER = 4'd11;
    localparam logic [4:0]  C_EXP_MAX   = 5'h1F;

    state_t             r_state;
    logic               r_sign;
    logic signed [6:0]  r_exp;
    logic [11:0]        r_rem;
    logic [10:0]        r_div;
    logic [11:0]        r_quo;
    logic [3:0]         r_cnt;
    logic               r_special;
    logic [15:0]        r_spec_val;

    // Operand decode; subnormals count as zero
    logic               w_sa, w_sb, w_sign;
    logic [4:0]         w_ea, w_eb;
    logic [9:0]         w_fa, w_fb;
    logic               w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [10:0]        w_ma, w_mb;
    logic signed [6:0]  w_exp_in;

    assign w_sa     = in_A[15];
    assign w_sb     = in_B[15];
    assign w_ea     = in_A[14:10];
    assign w_eb     = in_B[14:10];
    assign w_fa     = in_A[9:0];
    assign w_fb     = in_B[9:0];
    assign w_sign   = w_sa ^ w_sb;
    assign w_za     = (w_ea == 5'd0);
    assign w_zb     = (w_eb == 5'd0);
    assign w_ia     = (w_ea == C_EXP_MAX) && (w_fa == 10'd0);
    assign w_ib     = (w_eb == C_EXP_MAX) && (w_fb == 10'd0);
    assign w_na     = (w_ea == C_EXP_MAX) && (w_fa != 10'd0);
    assign w_nb     = (w_eb == C_EXP_MAX) && (w_fb != 10'd0);
    assign w_ma     = w_za ? 11'd0 : {1'b1, w_fa};
    assign w_mb     = w_zb ? 11'd0 : {1'b1, w_fb};
    assign w_exp_in = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 7'sd15;

    logic               w_special;
    logic [15:0]        w_spec_val;

    always_comb begin
        w_special  = 1'b0;
        w_spec_val = 16'h0000;
        if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
            w_special  = 1'b1;
            w_spec_val = C_QNAN;
        end else if (w_zb || w_ia) begin
            w_special  = 1'b1;
            w_spec_val = {w_sign, C_EXP_MAX, 10'd0};
        end else if (w_za || w_ib) begin
            w_special  = 1'b1;
            w_spec_val = {w_sign, 15'd0};
        end
    end

    // One restoring step: remainder stays below twice the divisor, so 12 bits suffice
    logic               w_ge;
    logic [11:0]        w_rem_sub;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    logic signed [6:0]  w_exp_norm;
    logic [9:0]         w_frac;
    logic [15:0]        w_result;

    assign w_exp_norm = r_quo[11] ? r_exp : (r_exp - 7'sd1);
    assign w_frac     = r_quo[11] ? r_quo[10:1] : r_quo[9:0];

    always_comb begin
        w_result = {r_sign, w_exp_norm[4:0], w_frac};
        if (r_special) begin
            w_result = r_spec_val;
        end else if (w_exp_norm <= 7'sd0) begin
            w_result = {r_sign, 15'd0};
        end else if (w_exp_norm >= 7'sd31) begin
            w_result = {r_sign, C_EXP_MAX, 10'd0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sign     <= 1'b0;
            r_exp      <= 7'sd0;
            r_rem      <= 12'd0;
            r_div      <= 11'd0;
            r_quo      <= 12'd0;
            r_cnt      <= 4'd0;
            r_special  <= 1'b0;
            r_spec_val <= 16'h0000;
            out_Out    <= 16'h0000;
            out_Ready  <= 1'b0;
        end else begin
            out_Ready <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (in_En) begin
                        r_sign     <= w_sign;
                        r_exp      <= w_exp_in;
                        r_rem      <= {1'b0, w_ma};
                        r_div      <= w_mb;
                        r_quo      <= 12'd0;
                        r_cnt      <= 4'd0;
                        r_special  <= w_special;
                        r_spec_val <= w_spec_val;
                        r_state    <= S_DIV;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[10:0], 1'b0};
                    r_quo <= {r_quo[10:0], w_ge};
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_NORM: begin
                    out_Out   <= w_result;
                    out_Ready <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mod_divide.md
MOD_DIVIDE -- requirements
Module: mod_Divide

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_A, input, 16, dividend in IEEE-754 binary16.
REQ-004 SHALL have port in_B, input, 16, divisor in IEEE-754 binary16.
REQ-005 SHALL have port in_En, input, 1, start request, sampled on the rising clk edge.
REQ-006 SHALL have port out_Out, output, 16, quotient A/B in binary16, registered.
REQ-007 SHALL have port out_Ready, output, 1, one-cycle pulse marking out_Out valid.

Function
REQ-010 SHALL implement a 4-state FSM: IDLE, DIV, NORM, DONE.
REQ-011 SHALL, in IDLE or DONE with in_En=1 at an edge: latch in_A and in_B, load remainder=mA and divisor=mB (hidden bit included), clear the quotient, and go to DIV.
REQ-012 SHALL ignore in_En in DIV and NORM; in_A and in_B may change freely after acceptance.
REQ-013 SHALL, in DIV, perform one restoring-division step per cycle for exactly 12 cycles, then go to NORM.
  - Each step: if rem >= mB, then q bit = 1 and rem = rem - mB; otherwise q bit = 0.
  - Then rem = rem << 1.
REQ-014 SHALL use a 4-bit iteration counter that resets to 0 on entry to DIV.
REQ-015 SHALL compute the exponent as e = eA - eB + 15, using a signed width of at least 7 bits.
REQ-016 SHALL, in NORM, normalize the quotient:
  - q[11]=1: fraction = q[10:1], exponent e.
  - Otherwise: fraction = q[9:0], exponent e-1.
REQ-017 SHALL round toward zero (truncate); no guard, round or sticky bits.
REQ-018 SHALL set the sign to sA XOR sB for every result except NaN.
REQ-019 SHALL treat subnormal inputs (exponent field 0) as signed zero.
REQ-020 SHALL flush to signed zero any result whose final exponent is <= 0.
REQ-021 SHALL saturate to signed infinity (exponent 31, fraction 0) any result whose final exponent is >= 31.
REQ-022 SHALL decode special cases at acceptance, in this priority order:
  - any NaN input, 0/0 or inf/inf -> 16'h7E00.
  - x/0 or inf/x -> signed inf.
  - 0/x or x/inf -> signed zero.
REQ-023 SHALL give special-case results the same latency as normal ones; the FSM still traverses DIV and NORM.
REQ-024 SHALL, at the edge leaving NORM, register out_Out, set out_Ready=1, and go to DONE.
REQ-025 SHALL, in DONE without in_En, clear out_Ready at the next edge and go to IDLE.
REQ-026 SHALL hold out_Out stable from DONE until the next result is registered.
REQ-027 SHALL meet this latency: accept at edge k produces out_Ready high from edge k+13 to edge k+14.
REQ-028 SHALL, when in_En=1 in DONE at edge k+14, accept a new operation back-to-back; out_Ready still falls at that edge.
REQ-029 SHALL never hold out_Ready high for more than one cycle per accepted operation.

Reset
REQ-040 SHALL, while rst=0, asynchronously force state=IDLE, out_Out=16'h0000, out_Ready=0, counter=0 and all datapath registers to 0.
REQ-041 SHALL, on assertion of rst mid-operation, abort the operation with no out_Ready pulse; the first accept after release starts cleanly.
REQ-042 SHALL, after rst release, first sample in_En at the next rising clk edge.

Verification
REQ-050 in_A=16'h4600 (6.0), in_B=16'h4000 (2.0), in_En pulsed -> 13 edges later out_Out=16'h4200 (3.0), out_Ready high for 1 cycle.
REQ-051 in_A=16'h3C00 (1.0), in_B=16'h4200 (3.0) -> out_Out=16'h3555 (truncated 1/3).
REQ-052 Special cases, each at 13-cycle latency:
  - 16'h3C00/16'h0000 -> 16'h7C00.
  - 16'hBC00/16'h0000 -> 16'hFC00.
  - 16'h0000/16'h0000 -> 16'h7E00.
  - 16'h0000/16'h5010 -> 16'h0000.
REQ-053 Range limits:
  - 16'h7BFF/16'h3800 -> 16'h7C00 (overflow).
  - 16'h0400/16'h4000 -> 16'h0000 (underflow flush).
REQ-054 Protocol:
  - in_En held high through DIV -> exactly one result.
  - in_En high in DONE -> second accept at edge k+14, second out_Ready at edge k+27.
REQ-055 rst=0 asserted at DIV iteration 5 -> out_Out=16'h0000, out_Ready=0 immediately (before next clk edge); no pulse afterward until a new accept.
